// File: rtl/cacheline_arbiter.sv
// Arbitrates one cacheline adaptor between the I-cache and D-cache, one whole-line transaction at a time.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: fixed D-over-I priority).
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_address_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic              m_read_o,
  output logic              m_write_o,
  output logic [ADDR_W-1:0] m_address_o,
  output logic [LINE_W-1:0] m_line_o,
  input  logic [LINE_W-1:0] m_line_i,
  input  logic              m_resp_i,
  output logic [1:0]        state_dbg,
  output logic              last_grant_dbg
);

  // Handshake: a requester holds read/write (its valid) until its own resp pulse, and the
  // arbiter holds m_read_o/m_write_o until m_resp_i; the resp pulse is the only acceptance.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = I-cache, 1 = D-cache
  logic   i_req;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;

  assign i_req = i_read_i;
  assign d_req = d_read_i | d_write_i;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, the cache that did not win last time takes the adaptor.
  assign grant_d = d_req & (~i_req | ~last_grant);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_read_o    <= 1'b0;
      m_write_o   <= 1'b0;
      m_address_o <= '0;
      m_line_o    <= '0;
      last_grant  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // A simultaneous D read and write is resolved as a read.
            state       <= SERVE_D;
            m_address_o <= d_address_i;
            m_line_o    <= d_line_i;
            m_read_o    <= d_read_i;
            m_write_o   <= ~d_read_i;
            last_grant  <= 1'b1;
          end else if (grant_i) begin
            state       <= SERVE_I;
            m_address_o <= i_address_i;
            m_line_o    <= '0;
            m_read_o    <= 1'b1;
            m_write_o   <= 1'b0;
            last_grant  <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (m_resp_i) begin
            state     <= DONE;
            m_read_o  <= 1'b0;
            m_write_o <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Responses go straight through to whichever cache owns the adaptor, nobody else.
  assign i_resp_o = m_resp_i & (state == SERVE_I) & ~rst;
  assign d_resp_o = m_resp_i & (state == SERVE_D) & ~rst;
  assign i_line_o = i_resp_o ? m_line_i : '0;
  assign d_line_o = d_resp_o ? m_line_i : '0;

  assign state_dbg      = state;
  assign last_grant_dbg = last_grant;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter: grant order, latency, line latching and resp routing.
module tb_cacheline_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_read_i;
  logic [ADDR_W-1:0] i_address_i;
  logic [LINE_W-1:0] i_line_o;
  logic              i_resp_o;
  logic              d_read_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_address_i;
  logic [LINE_W-1:0] d_line_i;
  logic [LINE_W-1:0] d_line_o;
  logic              d_resp_o;
  logic              m_read_o;
  logic              m_write_o;
  logic [ADDR_W-1:0] m_address_o;
  logic [LINE_W-1:0] m_line_o;
  logic [LINE_W-1:0] m_line_i;
  logic              m_resp_i;
  logic [1:0]        state_dbg;
  logic              last_grant_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int grant_cnt = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  int exp_i_resp = 0;
  int exp_d_resp = 0;
  logic prev_act = 1'b0;
  logic [ADDR_W-1:0] exp_q[$];

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_read_i       (i_read_i),
    .i_address_i    (i_address_i),
    .i_line_o       (i_line_o),
    .i_resp_o       (i_resp_o),
    .d_read_i       (d_read_i),
    .d_write_i      (d_write_i),
    .d_address_i    (d_address_i),
    .d_line_i       (d_line_i),
    .d_line_o       (d_line_o),
    .d_resp_o       (d_resp_o),
    .m_read_o       (m_read_o),
    .m_write_o      (m_write_o),
    .m_address_o    (m_address_o),
    .m_line_o       (m_line_o),
    .m_line_i       (m_line_i),
    .m_resp_i       (m_resp_i),
    .state_dbg      (state_dbg),
    .last_grant_dbg (last_grant_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) assert (!(d_read_i && d_write_i)) else $error("D-cache read and write asserted together");
  end

  // ---------------- scoreboard: grant order and resp counts ----------------
  always @(negedge clk) begin
    logic [ADDR_W-1:0] exp_addr;
    if ((m_read_o === 1'b1 || m_write_o === 1'b1) && !prev_act) begin
      grant_cnt++;
      check("grant_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_addr = exp_q.pop_front();
        check("grant_addr", m_address_o, exp_addr);
      end
    end
    prev_act = (m_read_o === 1'b1) || (m_write_o === 1'b1);
  end

  always @(posedge clk) begin
    if (i_resp_o === 1'b1) i_resp_cnt++;
    if (d_resp_o === 1'b1) d_resp_cnt++;
  end

  // ---------------- driver: adaptor model ----------------
  // Waits for the next memory request, lets one beat pass, then returns rline with a resp pulse.
  task automatic serve_one(input logic [LINE_W-1:0] rline, input bit exp_d, input int exp_wait);
    int n = 0;
    while (!(m_read_o === 1'b1 || m_write_o === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_latency", n, exp_wait);
    if (!(m_read_o === 1'b1 || m_write_o === 1'b1)) return;
    @(negedge clk);
    m_resp_i = 1'b1;
    m_line_i = rline;
    #1;
    check("i_resp", i_resp_o, !exp_d);
    check("d_resp", d_resp_o, exp_d);
    check("i_line", i_line_o, exp_d ? '0 : rline);
    check("d_line", d_line_o, exp_d ? rline : '0);
    if (exp_d) exp_d_resp++;
    else exp_i_resp++;
    @(negedge clk);
    m_resp_i = 1'b0;
    m_line_i = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [LINE_W-1:0] line_a;
    logic [LINE_W-1:0] line_b;
    rst = 1'b1;
    i_read_i = 1'b0; i_address_i = '0;
    d_read_i = 1'b0; d_write_i = 1'b0; d_address_i = '0; d_line_i = '0;
    m_line_i = '0; m_resp_i = 1'b0;
    line_a = {8{32'hDEADBEEF}};
    line_b = {4{64'h0123_4567_89AB_CDEF}};
    repeat (2) @(negedge clk);

    check("rst_state", state_dbg, 2'd0);
    check("rst_m_read", m_read_o, 1'b0);
    check("rst_m_write", m_write_o, 1'b0);
    check("rst_m_address", m_address_o, '0);
    check("rst_m_line", m_line_o, '0);
    check("rst_i_resp", i_resp_o, 1'b0);
    check("rst_d_resp", d_resp_o, 1'b0);
    check("rst_last_grant", last_grant_dbg, 1'b0);
    rst = 1'b0;

    // I-cache read, request held through DONE
    exp_q.push_back(32'h0000_1000);
    i_read_i = 1'b1; i_address_i = 32'h0000_1000;
    @(negedge clk);
    check("t1_m_read", m_read_o, 1'b1);
    check("t1_m_write", m_write_o, 1'b0);
    check("t1_state", state_dbg, 2'd1);
    check("t1_last_grant", last_grant_dbg, 1'b0);
    i_address_i = 32'h0000_BEEF;
    serve_one(line_a, 1'b0, 0);
    check("t1_done_state", state_dbg, 2'd3);
    check("t1_drop_read", m_read_o, 1'b0);
    check("t1_addr_hold", m_address_o, 32'h0000_1000);
    @(negedge clk);
    check("t1_idle_state", state_dbg, 2'd0);
    i_read_i = 1'b0;
    @(negedge clk);
    check("t1_no_dup_read", m_read_o, 1'b0);
    check("t1_grant_cnt", grant_cnt, 1);

    // D-cache write, upstream changes ignored while served
    exp_q.push_back(32'h0000_2040);
    d_write_i = 1'b1; d_address_i = 32'h0000_2040; d_line_i = {32{8'hA5}};
    @(negedge clk);
    check("t2_m_write", m_write_o, 1'b1);
    check("t2_m_read", m_read_o, 1'b0);
    check("t2_m_line", m_line_o, {32{8'hA5}});
    check("t2_state", state_dbg, 2'd2);
    check("t2_last_grant", last_grant_dbg, 1'b1);
    d_line_i = {32{8'h5A}}; d_address_i = 32'h9999_0000;
    @(negedge clk);
    check("t2_line_hold", m_line_o, {32{8'hA5}});
    check("t2_addr_hold", m_address_o, 32'h0000_2040);
    serve_one(line_b, 1'b1, 0);
    d_write_i = 1'b0;
    check("t2_drop_write", m_write_o, 1'b0);
    @(negedge clk);

    // Spurious adaptor response while idle
    m_resp_i = 1'b1; m_line_i = '1;
    #1;
    check("sp_i_resp", i_resp_o, 1'b0);
    check("sp_d_resp", d_resp_o, 1'b0);
    check("sp_d_line", d_line_o, '0);
    @(negedge clk);
    m_resp_i = 1'b0; m_line_i = '0;
    check("sp_state", state_dbg, 2'd0);
    check("sp_no_req", m_read_o | m_write_o, 1'b0);

    // Simultaneous requests held across three transactions
    do_reset();
    check("tie_last_grant_rst", last_grant_dbg, 1'b0);
    i_read_i = 1'b1; i_address_i = 32'h0000_3000;
    d_read_i = 1'b1; d_address_i = 32'h0000_4000;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(32'h0000_4000);
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'h0000_4000);
    serve_one(line_a, 1'b1, 1);
    serve_one(line_b, 1'b0, 2);
    serve_one(line_a, 1'b1, 2);
`else
    exp_q.push_back(32'h0000_4000);
    exp_q.push_back(32'h0000_4000);
    exp_q.push_back(32'h0000_4000);
    serve_one(line_a, 1'b1, 1);
    serve_one(line_b, 1'b1, 2);
    serve_one(line_a, 1'b1, 2);
`endif
    i_read_i = 1'b0; d_read_i = 1'b0;
    check("tie_last_grant", last_grant_dbg, 1'b1);
    repeat (3) @(negedge clk);
    check("tie_idle", state_dbg, 2'd0);

    // Reset in the middle of a D write, then reissue
    exp_q.push_back(32'h0000_5000);
    exp_q.push_back(32'h0000_5000);
    d_write_i = 1'b1; d_address_i = 32'h0000_5000; d_line_i = line_b;
    @(negedge clk);
    check("rs_m_write", m_write_o, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1; m_resp_i = 1'b1; m_line_i = line_a;
    #1;
    check("rs_d_resp_gated", d_resp_o, 1'b0);
    @(negedge clk);
    m_resp_i = 1'b0; m_line_i = '0;
    check("rs_m_write_drop", m_write_o, 1'b0);
    check("rs_state", state_dbg, 2'd0);
    check("rs_m_line_clr", m_line_o, '0);
    rst = 1'b0;
    serve_one(line_a, 1'b1, 1);
    d_write_i = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_queue_empty", exp_q.size(), 0);
    check("sb_i_resp_cnt", i_resp_cnt, exp_i_resp);
    check("sb_d_resp_cnt", d_resp_cnt, exp_d_resp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
